// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the decode stage: opcodes, field positions, ALU ops, ID/EX control bundle.
package cpu_isa_pkg;

  localparam int ISA_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_SUB  = 4'h2;
  localparam logic [3:0] OPC_AND  = 4'h3;
  localparam logic [3:0] OPC_OR   = 4'h4;
  localparam logic [3:0] OPC_XOR  = 4'h5;
  localparam logic [3:0] OPC_SHL  = 4'h6;
  localparam logic [3:0] OPC_SHR  = 4'h7;
  localparam logic [3:0] OPC_ADDI = 4'h8;
  localparam logic [3:0] OPC_LD   = 4'h9;
  localparam logic [3:0] OPC_ST   = 4'hA;
  localparam logic [3:0] OPC_BEQ  = 4'hB;
  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_HALT = 4'hF;

  // Register-register ALU ops share their opcode value so decode is a pass-through.
  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_SHL = 4'h6,
    ALU_SHR = 4'h7
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [3:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       halt;
    logic       illegal;
  } idex_ctrl_t;

  function automatic logic [ISA_W-1:0] sext_imm4(input logic [3:0] imm);
    return {{(ISA_W-4){imm[3]}}, imm};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder: read addresses, source-use flags, control bundle, immediate.
// Latency: none (pure combinational). Backpressure: none; the enclosing stage decides when to use it.
// Sub-module of id_stage.
module id_decoder
  import cpu_isa_pkg::*;
(
  input  logic [ISA_W-1:0] instr,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic             use_rs1,
  output logic             use_rs2,
  output idex_ctrl_t       ctrl,
  output logic [ISA_W-1:0] imm
);

  logic [3:0] opc;
  logic [3:0] f_rd;
  logic [3:0] f_rs1;
  logic [3:0] f_rs2;
  logic       wb;

  assign opc   = instr[OPC_MSB:OPC_LSB];
  assign f_rd  = instr[RD_MSB:RD_LSB];
  assign f_rs1 = instr[RS1_MSB:RS1_LSB];
  assign f_rs2 = instr[RS2_MSB:RS2_LSB];
  assign imm   = sext_imm4(f_rs2);

  always_comb begin
    rs1     = f_rs1;
    rs2     = f_rs2;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wb      = 1'b0;
    ctrl    = '0;
    ctrl.rd = f_rd;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        wb          = 1'b1;
        ctrl.alu_op = alu_op_e'(opc);
      end
      OPC_ADDI: begin
        use_rs1     = 1'b1;
        wb          = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      OPC_LD: begin
        use_rs1       = 1'b1;
        wb            = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.mem_read = 1'b1;
      end
      OPC_ST: begin
        // Store data comes from the rd field through read port 2.
        rs2            = f_rd;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_write = 1'b1;
      end
      OPC_BEQ: begin
        rs1         = f_rd;
        rs2         = f_rs1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OPC_JMP: begin
        use_rs1   = 1'b1;
        ctrl.jump = 1'b1;
      end
      OPC_HALT: ctrl.halt = 1'b1;
      OPC_NOP:  ;
      default:  ctrl.illegal = 1'b1;
    endcase
    ctrl.reg_write = wb && (f_rd != 4'd0);
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decodes if_instr, captures operands into the ID/EX register, inserts load-use bubbles, sticky halt.
// Latency: one cycle from acceptance to ex_* outputs.
// Backpressure: id_ready drops on ex_stall, load-use hazard and after HALT; ex_flush overrides all and accepts.
module id_stage
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [PC_W-1:0]   if_pc,
  output logic              id_ready,
  output logic [3:0]        rf_rs1,
  output logic [3:0]        rf_rs2,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_op,
  output logic [3:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rs1_val,
  output logic [DATA_W-1:0] ex_rs2_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_illegal,
  output logic              halted
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e           state_q, state_d;
  logic             use_rs1, use_rs2;
  idex_ctrl_t       ctrl;
  logic [ISA_W-1:0] imm;
  logic             hazard;
  logic             load_en;
  logic             take;

  id_decoder u_dec (
    .instr   (if_instr),
    .rs1     (rf_rs1),
    .rs2     (rf_rs2),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .ctrl    (ctrl),
    .imm     (imm)
  );

  assign hazard = if_valid && ex_valid && ex_mem_read && (ex_rd != 4'd0) &&
                  ((use_rs1 && (rf_rs1 == ex_rd)) || (use_rs2 && (rf_rs2 == ex_rd)));

  assign halted = (state_q == HALTED);

  // Priority: flush > stall > hazard > halted > normal issue.
  always_comb begin
    state_d  = state_q;
    id_ready = 1'b0;
    load_en  = 1'b1;
    take     = 1'b0;
    if (ex_flush) begin
      id_ready = 1'b1;
    end else if (ex_stall) begin
      load_en = 1'b0;
    end else if (hazard || state_q == HALTED) begin
      take = 1'b0;
    end else begin
      id_ready = 1'b1;
      if (if_valid) begin
        take = 1'b1;
        if (ctrl.halt) state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= '0;
      ex_rd        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (load_en) begin
      if (take) begin
        ex_valid     <= 1'b1;
        ex_alu_op    <= ctrl.alu_op;
        ex_rd        <= ctrl.rd;
        ex_rs1_val   <= rf_rs1_data;
        ex_rs2_val   <= rf_rs2_data;
        ex_imm       <= imm;
        ex_pc        <= if_pc;
        ex_reg_write <= ctrl.reg_write;
        ex_mem_read  <= ctrl.mem_read;
        ex_mem_write <= ctrl.mem_write;
        ex_branch    <= ctrl.branch;
        ex_jump      <= ctrl.jump;
        ex_illegal   <= ctrl.illegal;
      end else begin
        ex_valid     <= 1'b0;
        ex_alu_op    <= '0;
        ex_rd        <= '0;
        ex_rs1_val   <= '0;
        ex_rs2_val   <= '0;
        ex_imm       <= '0;
        ex_pc        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_branch    <= 1'b0;
        ex_jump      <= 1'b0;
        ex_illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 16-bit pipeline. Sits between the fetch stage and the execute stage.
- Splits the incoming instruction into fields and drives the register-file read addresses. Captures the combinational register-file read data into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles. Honours execute-stage flush and stall.
- Holds a sticky halt after a HALT instruction issues.

Parameters:
- DATA_W, 16, datapath and instruction width.
- PC_W, 16, program counter width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_instr  in  16  instruction word
- if_pc  in  16  PC of if_instr
- id_ready  out  1  stage accepts if_instr this cycle
- rf_rs1  out  4  register-file read address 1
- rf_rs2  out  4  register-file read address 2
- rf_rs1_data  in  16  register-file read data 1 (combinational, already forwarded)
- rf_rs2_data  in  16  register-file read data 2
- ex_stall  in  1  execute cannot accept; hold the ID/EX register
- ex_flush  in  1  branch taken; kill the instruction in decode
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_alu_op  out  4  ALU operation
- ex_rd  out  4  destination register
- ex_rs1_val  out  16  operand 1
- ex_rs2_val  out  16  operand 2 / store data
- ex_imm  out  16  sign-extended imm4
- ex_pc  out  16  PC of the instruction
- ex_reg_write  out  1  writeback enable
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_branch  out  1  BEQ
- ex_jump  out  1  JMP
- ex_illegal  out  1  undefined opcode, issued as a NOP
- halted  out  1  HALT has issued

Behaviour:
- Reset is asynchronous, active-low (rst_n). All ex_* outputs reset to 0; halted resets to 0; FSM resets to RUN.
- Instruction format:
  - opcode = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0].
  - imm4 = [3:0], sign-extended to 16 bits.
- Opcode map:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 SHL; 7 SHR.
  - 8 ADDI (rd = rs1 + imm).
  - 9 LD (rd = mem[rs1 + imm]).
  - A ST (mem[rs1 + imm] = R[rd]); rf_rs2 = [11:8].
  - B BEQ (rd and rs1 compared, offset imm); rf_rs1 = [11:8], rf_rs2 = [7:4].
  - C JMP (target = rs1).
  - F HALT.
  - D and E are illegal: issued with all enables 0 and ex_illegal = 1.
- Writes to R0: ex_reg_write is forced to 0 when rd == 0.
- Read addresses are combinational from if_instr every cycle.
- Source-use flags per opcode:
  - ADD..SHR: rs1 and rs2.
  - ADDI, LD, JMP: rs1 only.
  - ST, BEQ: both remapped sources.
  - NOP, HALT: none.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd != 0 & ex_rd matches a used source of a valid if_instr.
- Cycle priority, evaluated at each posedge clk:
  1. ex_flush: ID/EX register loads a bubble (ex_valid = 0, all enables 0); id_ready = 1 so fetch advances and discards.
  2. ex_stall: ID/EX register holds its value; id_ready = 0.
  3. Hazard: ID/EX register loads a bubble; id_ready = 0; the instruction is re-decoded next cycle. This gives exactly one bubble per load-use.
  4. HALTED: bubble; id_ready = 0.
  5. Normal: if if_valid, load the decoded fields, ex_valid = 1; otherwise load a bubble.
- id_ready is combinational from the same priority: 1 only under flush, or under normal with state RUN.
- FSM states and transitions:
  - RUN to HALTED when HALT loads into ID/EX; halted = 1 from the next cycle.
  - HALTED is left only by reset.
  - A HALT killed by ex_flush does not halt.
- Latency: one cycle from acceptance to ex_* outputs.
- Operands are captured from rf_* in the accept cycle. Writeback forwarding is the register file's job; no forwarding happens here.
- Reset mid-stall or mid-hazard returns immediately to empty/RUN; there is no residual bubble count.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode constants;
  - field bit positions;
  - ALU op encodings;
  - the imm4 sign-extension function;
  - ID/EX control-bundle typedef.
- Sub-module id_decoder (combinational): instruction in; read addresses, source-use flags, control bundle, imm and illegal out.
- id_stage holds the pipeline register, the hazard/priority logic and the halt FSM.

Test Plan:
- Reset: rst_n low mid-run → all ex_* = 0, halted = 0 asynchronously; ADD R3,R1,R2 after release with rf data 0x0005/0x0007 → next cycle ex_valid = 1, ex_rs1_val = 0x0005, ex_rs2_val = 0x0007, ex_rd = 3, ex_reg_write = 1.
- Load-use: LD R4,[R1+2] then ADD R5,R4,R2 → one bubble cycle (ex_valid = 0, id_ready = 0), then ADD issues; ADD R5,R6,R2 after the load → no bubble.
- ADDI R2,R0,-1 (0x820F) → ex_imm = 0xFFFF; ADDI R0,R1,3 → ex_reg_write = 0.
- ex_stall held 3 cycles → ex_* unchanged, id_ready = 0; simultaneous ex_flush and ex_stall → bubble, id_ready = 1.
- Opcode 0xD → ex_illegal = 1, all enables 0; HALT (0xF000) → halted = 1 the following cycle, id_ready = 0 thereafter; HALT coincident with ex_flush → halted stays 0.
- ST R7,[R1+0] (0xA710) → rf_rs2 = 7, ex_mem_write = 1, ex_reg_write = 0; BEQ R2,R3,+1 → rf_rs1 = 2, rf_rs2 = 3, ex_branch = 1.
